wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback
//  (WB data mux output) and late results from a multi-cycle unit (e.g. divider).
//  Pipeline writes always win. Multi-cycle results wait in a small FIFO and drain into
//  free write-port cycles. Squashes stale pending results (WAW) and raises a stall when
//  the FIFO is full or starved.
// PARAMETERS
//  DATA_W      16  register data width (matches data bus)
//  ADDR_W      4   register address width
//  DEPTH       2   pending-result FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   consecutive pipeline-blocked drain cycles before a forced stall
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active-high
//  pipe_we    in   1       pipeline writeback valid (never back-pressured)
//  pipe_addr  in   ADDR_W  pipeline destination register
//  pipe_data  in   DATA_W  pipeline write data (WB mux output)
//  mc_valid   in   1       multi-cycle result valid
//  mc_addr    in   ADDR_W  multi-cycle destination register
//  mc_data    in   DATA_W  multi-cycle result
//  mc_ready   out  1       FIFO can accept (transfer = mc_valid & mc_ready)
//  rf_we      out  1       register-file write enable (registered)
//  rf_addr    out  ADDR_W  register-file write address (registered)
//  rf_data    out  DATA_W  register-file write data (registered)
//  stall_req  out  1       to hazard unit: freeze pipeline, pipe_we must be 0 next cycle
// BEHAVIOUR
//  Reset: rf_we=0, rf_addr=0, rf_data=0, stall_req=0, FIFO empty, starve_cnt=0, state IDLE.
//   Reset mid-operation flushes pending entries; they are lost, no write issued.
//  Entry = {live, addr, data}. Accept sets live=1 at tail. mc_ready = (count<DEPTH), from regs.
//  Per cycle, write-port owner decided from current inputs; rf_* registered on clk edge:
//   pipe_we=1          -> rf_* <= pipe; head not popped.
//   pipe_we=0, count>0 -> pop head; rf_we <= head.live, rf_addr/rf_data <= head.
//   else               -> rf_we <= 0; rf_addr/rf_data hold.
//  Latency: pipe write visible on rf_* 1 cycle later; accepted mc result earliest drains
//   the cycle after acceptance (on rf_* 2 cycles after mc transfer). No same-cycle bypass.
//  WAW squash: pipe_we with pipe_addr == live entry addr clears that entry's live bit (all
//   matches). An entry accepted the same cycle with the same addr is NOT squashed (younger).
//  Killed head still consumes a drain cycle (rf_we=0).
//  Simultaneous accept + pop: count unchanged; pointers wrap modulo DEPTH.
//  FSM (registered):
//   IDLE  : count==0. -> PEND on accept.
//   PEND  : count>0. starve_cnt++ each cycle pipe_we blocks a non-empty FIFO, cleared on pop.
//           -> STALL when starve_cnt==STARVE_MAX-1 and blocked again; -> IDLE when count
//           becomes 0.
//   STALL : stall_req=1; pipe_we is 0 by contract, head pops. -> PEND/IDLE after pop,
//           starve_cnt=0.
//   pipe_we=1 in STALL is a protocol error: pipe write still wins, stay STALL.
//  stall_req = (state==STALL) | (mc_valid & ~mc_ready).
// CONFIGURATION
//  WB_ARB_FWD_EN defined: extra ports fwd_addr in ADDR_W, fwd_hit out 1, fwd_data out DATA_W.
//   Combinational lookup; fwd_hit=1 if any live entry matches fwd_addr, fwd_data = youngest
//   match. Entry popped this cycle still matches.
//  Undefined: ports absent, no lookup logic; hazard unit must stall on pending addrs.
// TESTING
//  T1 reset: assert rst mid-drain with 2 entries -> rf_we=0, mc_ready=1, no later write.
//  T2 pipe only: pipe_we=1,addr=3,data=16'h1234 -> next cycle rf_we=1,rf_addr=3,rf_data=h1234.
//  T3 drain: mc (5,h00AA) accepted, pipe idle -> rf_we=1,addr=5,data=h00AA 2 cycles later.
//  T4 full: 2 mc results with pipe_we held 1, third mc_valid -> mc_ready=0, stall_req=1,
//     entries drain in order once pipe idles.
//  T5 WAW: pending (2,h1111), pipe (2,h2222) -> rf gets h2222 only; head drain cycle rf_we=0.
//  T6 starve: pipe_we=1 for STARVE_MAX cycles with entry pending -> stall_req=1; entry
//     written; stall_req drops the next cycle.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and queued multi-cycle results.
// Optional forwarding lookup into pending results is enabled by defining WB_ARB_FWD_EN.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              stall_req
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;

    logic [DEPTH-1:0]  live_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    state_t            state_q, state_d;
    logic              accept, pop, blocked;

    assign mc_ready  = (count_q < CNT_W'(DEPTH));
    assign accept    = mc_valid & mc_ready;
    assign pop       = ~pipe_we & (count_q != '0);
    assign blocked   = pipe_we & (count_q != '0);
    assign count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
    assign stall_req = (state_q == STALL) | (mc_valid & ~mc_ready);

    // Pending-result FIFO; squash precedes accept so a same-cycle younger entry survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[PTR_W'(i)] <= '0;
                data_q[PTR_W'(i)] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + PTR_W'(1);
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pipe_we && live_q[PTR_W'(i)] && (addr_q[PTR_W'(i)] == pipe_addr))
                    live_q[PTR_W'(i)] <= 1'b0;
            end
            if (accept) begin
                live_q[tail_q] <= 1'b1;
                addr_q[tail_q] <= mc_addr;
                data_q[tail_q] <= mc_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
        end
    end

    // Write-port mux: pipeline first, then FIFO head (killed head still uses the slot).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (pipe_we) begin
            rf_we   <= 1'b1;
            rf_addr <= pipe_addr;
            rf_data <= pipe_data;
        end else if (count_q != '0) begin
            rf_we   <= live_q[head_q];
            rf_addr <= addr_q[head_q];
            rf_data <= data_q[head_q];
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Starvation tracking: count blocked drain cycles, force a stall on the limit.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = PEND;
            end
            PEND: begin
                if (pop) begin
                    starve_d = '0;
                    state_d  = (count_d == '0) ? IDLE : PEND;
                end else if (blocked) begin
                    if (starve_q == SC_W'(STARVE_MAX - 1)) state_d = STALL;
                    else                                   starve_d = starve_q + SC_W'(1);
                end
            end
            STALL: begin
                if (pop) begin
                    starve_d = '0;
                    state_d  = (count_d == '0) ? IDLE : PEND;
                end
            end
            default: begin
                state_d  = IDLE;
                starve_d = '0;
            end
        endcase
    end

`ifdef WB_ARB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Oldest-to-youngest scan so the youngest live match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (live_q[fwd_idx] && (addr_q[fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default build, DEPTH=2, STARVE_MAX=4).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [3:0]  pipe_addr;
    logic [15:0] pipe_data;
    logic        mc_valid;
    logic [3:0]  mc_addr;
    logic [15:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic        stall_req;
`ifdef WB_ARB_FWD_EN
    logic [3:0]  fwd_addr = '0;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    wb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
        .mc_ready(mc_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .stall_req(stall_req)
`ifdef WB_ARB_FWD_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input logic [3:0] a, input logic [15:0] d);
        pipe_we = we; pipe_addr = a; pipe_data = d;
    endtask

    task automatic set_mc(input logic v, input logic [3:0] a, input logic [15:0] d);
        mc_valid = v; mc_addr = a; mc_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pipe(0, 0, 0);
        set_mc(0, 0, 0);
        step(); step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
        n_cmp++; if (rf_addr !== 4'h0) begin n_err++; $display("FAIL reset_rf_addr: got %h expected 0", rf_addr); end
        n_cmp++; if (rf_data !== 16'h0) begin n_err++; $display("FAIL reset_rf_data: got %h expected 0", rf_data); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        n_cmp++; if (mc_ready !== 1'b1) begin n_err++; $display("FAIL reset_mc_ready: got %b expected 1", mc_ready); end
        @(negedge clk);
        rst = 1'b0;
        // Fill two entries while the pipeline holds the port, then reset mid-drain.
        set_pipe(1, 4'h1, 16'h0001);
        set_mc(1, 4'h7, 16'h0707);
        step();
        set_mc(1, 4'h8, 16'h0808);
        step();
        set_pipe(0, 0, 0);
        set_mc(0, 0, 0);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h7 || rf_data !== 16'h0707) begin
            n_err++; $display("FAIL t1_first_drain: got we=%b a=%h d=%h expected we=1 a=7 d=0707", rf_we, rf_addr, rf_data);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rf_we !== 1'b0 || rf_addr !== 4'h0 || rf_data !== 16'h0) begin
            n_err++; $display("FAIL t1_async_reset: got we=%b a=%h d=%h expected we=0 a=0 d=0000", rf_we, rf_addr, rf_data);
        end
        n_cmp++; if (mc_ready !== 1'b1) begin n_err++; $display("FAIL t1_mc_ready: got %b expected 1", mc_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t1_no_write_after_reset[%0d]: got %b expected 0", i, rf_we); end
        end
    endtask

    task automatic test_pipe_only();
        set_pipe(1, 4'h3, 16'h1234);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h3 || rf_data !== 16'h1234) begin
            n_err++; $display("FAIL t2_pipe: got we=%b a=%h d=%h expected we=1 a=3 d=1234", rf_we, rf_addr, rf_data);
        end
        set_pipe(0, 0, 0);
        step();
        n_cmp++; if (rf_we !== 1'b0 || rf_addr !== 4'h3 || rf_data !== 16'h1234) begin
            n_err++; $display("FAIL t2_idle_hold: got we=%b a=%h d=%h expected we=0 a=3 d=1234", rf_we, rf_addr, rf_data);
        end
    endtask

    task automatic test_drain();
        set_mc(1, 4'h5, 16'h00AA);
        #1;
        n_cmp++; if (mc_ready !== 1'b1) begin n_err++; $display("FAIL t3_ready: got %b expected 1", mc_ready); end
        step();
        set_mc(0, 0, 0);
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t3_no_bypass: got %b expected 0", rf_we); end
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h5 || rf_data !== 16'h00AA) begin
            n_err++; $display("FAIL t3_drain: got we=%b a=%h d=%h expected we=1 a=5 d=00aa", rf_we, rf_addr, rf_data);
        end
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t3_empty_after: got %b expected 0", rf_we); end
    endtask

    task automatic test_full();
        set_pipe(1, 4'h1, 16'h0101);
        set_mc(1, 4'h9, 16'h0909);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h1 || rf_data !== 16'h0101) begin
            n_err++; $display("FAIL t4_pipe_wins: got we=%b a=%h d=%h expected we=1 a=1 d=0101", rf_we, rf_addr, rf_data);
        end
        set_mc(1, 4'hA, 16'h0A0A);
        step();
        set_mc(1, 4'hB, 16'h0B0B);
        #1;
        n_cmp++; if (mc_ready !== 1'b0) begin n_err++; $display("FAIL t4_full_ready: got %b expected 0", mc_ready); end
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL t4_full_stall: got %b expected 1", stall_req); end
        set_pipe(0, 0, 0);
        set_mc(0, 0, 0);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h9 || rf_data !== 16'h0909) begin
            n_err++; $display("FAIL t4_drain0: got we=%b a=%h d=%h expected we=1 a=9 d=0909", rf_we, rf_addr, rf_data);
        end
        n_cmp++; if (mc_ready !== 1'b1 || stall_req !== 1'b0) begin
            n_err++; $display("FAIL t4_after_pop: got ready=%b stall=%b expected ready=1 stall=0", mc_ready, stall_req);
        end
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'hA || rf_data !== 16'h0A0A) begin
            n_err++; $display("FAIL t4_drain1: got we=%b a=%h d=%h expected we=1 a=a d=0a0a", rf_we, rf_addr, rf_data);
        end
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t4_empty: got %b expected 0", rf_we); end
    endtask

    task automatic test_waw();
        set_mc(1, 4'h2, 16'h1111);
        step();
        set_mc(0, 0, 0);
        set_pipe(1, 4'h2, 16'h2222);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h2 || rf_data !== 16'h2222) begin
            n_err++; $display("FAIL t5_pipe: got we=%b a=%h d=%h expected we=1 a=2 d=2222", rf_we, rf_addr, rf_data);
        end
        set_pipe(0, 0, 0);
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t5_killed_head: got %b expected 0", rf_we); end
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL t5_no_late_write: got %b expected 0", rf_we); end
        // Same-cycle accept with matching pipe address is younger and must survive.
        set_pipe(1, 4'h6, 16'h6666);
        set_mc(1, 4'h6, 16'h0606);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_data !== 16'h6666) begin
            n_err++; $display("FAIL t5_same_cycle_pipe: got we=%b d=%h expected we=1 d=6666", rf_we, rf_data);
        end
        set_pipe(0, 0, 0);
        set_mc(0, 0, 0);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'h6 || rf_data !== 16'h0606) begin
            n_err++; $display("FAIL t5_younger_kept: got we=%b a=%h d=%h expected we=1 a=6 d=0606", rf_we, rf_addr, rf_data);
        end
    endtask

    task automatic test_starve();
        step();
        set_mc(1, 4'hC, 16'h0C0C);
        step();
        set_mc(0, 0, 0);
        set_pipe(1, 4'h1, 16'h1111);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL t6_early_stall[%0d]: got %b expected 0", i, stall_req); end
        end
        step();
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL t6_stall: got %b expected 1", stall_req); end
        set_pipe(0, 0, 0);
        step();
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'hC || rf_data !== 16'h0C0C) begin
            n_err++; $display("FAIL t6_drain: got we=%b a=%h d=%h expected we=1 a=c d=0c0c", rf_we, rf_addr, rf_data);
        end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL t6_stall_drop: got %b expected 0", stall_req); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'hA001; exp_d[1] = 16'hB002; exp_d[2] = 16'hC003;
        for (int i = 0; i < 3; i++) begin
            set_pipe(1, 4'(i + 1), exp_d[i]);
            step();
            n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'(i + 1) || rf_data !== exp_d[i]) begin
                n_err++; $display("FAIL b2b_pipe[%0d]: got we=%b a=%h d=%h expected we=1 a=%h d=%h", i, rf_we, rf_addr, rf_data, 4'(i + 1), exp_d[i]);
            end
        end
        set_pipe(0, 0, 0);
        // Streaming mc results: accept and pop together, pointers wrap.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_mc(1, 4'(i + 4), 16'h5500 + 16'(i));
            else       set_mc(0, 0, 0);
            step();
            if (i > 0) begin
                n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 4'(i + 3) || rf_data !== 16'h5500 + 16'(i - 1)) begin
                    n_err++; $display("FAIL b2b_mc[%0d]: got we=%b a=%h d=%h expected we=1 a=%h d=%h", i, rf_we, rf_addr, rf_data, 4'(i + 3), 16'h5500 + 16'(i - 1));
                end
                n_cmp++; if (mc_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, mc_ready); end
            end
        end
        step();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b expected 0", rf_we); end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_drain();
        test_full();
        test_waw();
        test_starve();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
